// File: rtl/dot_score_tracker.sv
// Dot-eating score tracker: on each frame tick, scans a snapshot of the dot grid row by row,
// counts newly eaten dots against the previous snapshot, and updates score / dots remaining.
module dot_score_tracker #(
  parameter int TOTAL_DOTS = 200,
  parameter int DOT_POINTS = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [307:0] show,
  input  logic         frame_tick,
  output logic [15:0]  score,
  output logic [8:0]   dots_left,
  output logic         eat_pulse,
  output logic         level_clear,
  output logic         busy
);

  // state  | meaning
  // IDLE   | waiting for frame_tick; snapshot taken on the tick
  // SCAN   | one 14-bit row of the snapshot per cycle, rows 0..21
  // UPDATE | commit score / dots_left / prev, raise eat_pulse
  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t        state, state_nxt;
  logic [307:0]  snap, prev;
  logic [4:0]    row;
  logic [8:0]    acc;
  logic [13:0]   row_bits;
  logic [3:0]    row_new;
  logic [31:0]   score_sum;
  logic [8:0]    dots_nxt;

  always_comb begin
    row_bits = snap[int'(row)*14 +: 14] & ~prev[int'(row)*14 +: 14];
    // Ghost box (row 11, cols 4..9) is always shown as 1 and never counts
    if (row == 5'd11) row_bits[9:4] = '0;
    row_new = '0;
    for (int i = 0; i < 14; i++) row_new = row_new + 4'(row_bits[i]);
  end

  always_comb begin
    score_sum = 32'(score) + 32'(DOT_POINTS) * 32'(acc);
    dots_nxt  = (acc >= dots_left) ? '0 : dots_left - acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = SCAN;
      SCAN:    if (row == 5'd21) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      score       <= '0;
      dots_left   <= 9'(TOTAL_DOTS);
      eat_pulse   <= 1'b0;
      level_clear <= 1'b0;
      prev        <= '0;
      snap        <= '0;
      row         <= '0;
      acc         <= '0;
    end else begin
      state     <= state_nxt;
      eat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            snap <= show;
            row  <= '0;
            acc  <= '0;
          end
        end
        SCAN: begin
          acc <= acc + 9'(row_new);
          row <= row + 5'd1;
        end
        UPDATE: begin
          prev      <= snap;
          score     <= (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
          dots_left <= dots_nxt;
          eat_pulse <= (acc != 9'd0);
          if (dots_nxt == 9'd0) level_clear <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/dot_score_tracker.md
DOT_SCORE_TRACKER -- requirements
Module: dot_score_tracker

Interface
REQ-001 SHALL have parameter TOTAL_DOTS, default 200: number of edible dots in the level.
REQ-002 SHALL have parameter DOT_POINTS, default 10: score added per newly eaten dot.
REQ-003 SHALL have port Clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port show  input  308: dot-grid status from the dot grid.
  - Bit 1 = dot eaten/hidden; bit index = row*14 + col; rows 0..21, cols 0..13.
REQ-006 SHALL have port frame_tick  input  1: one-cycle pulse, once per video frame, requests a scan.
REQ-007 SHALL have port score  output  16: accumulated score.
REQ-008 SHALL have port dots_left  output  9: edible dots remaining.
REQ-009 SHALL have port eat_pulse  output  1: one-cycle pulse when a scan found >=1 newly eaten dot.
REQ-010 SHALL have port level_clear  output  1: sticky flag, all edible dots eaten.
REQ-011 SHALL have port busy  output  1: high while a scan/update is in progress.

Function
REQ-012 SHALL implement states IDLE, SCAN, UPDATE.
REQ-013 In IDLE with frame_tick=1 at an edge, SHALL capture show into snap, clear row counter and frame accumulator, and enter SCAN.
REQ-014 In SCAN, SHALL process one row (14 bits) per cycle, rows 0..21 in order; 22 cycles total.
  - Last row -> UPDATE.
REQ-015 Per row, new = popcount(snap_row & ~prev_row) (0..14); SHALL add it to a 9-bit frame accumulator.
REQ-016 SHALL exclude ghost-box bits 158..163 (row 11, cols 4..9) from all counts; these bits are always 1 in show.
REQ-017 UPDATE lasts one cycle, then -> IDLE; it SHALL:
  - prev <= snap.
  - score <= score + DOT_POINTS*acc, saturating at 16'hFFFF.
  - dots_left <= dots_left - acc, floored at 0.
  - eat_pulse <= (acc != 0).
REQ-018 SHALL set level_clear in UPDATE when the new dots_left is 0; it SHALL stay set until Reset.
REQ-019 eat_pulse SHALL be high exactly one cycle: the cycle after UPDATE.
REQ-020 busy SHALL be 1 whenever state != IDLE.
REQ-021 Latency: if frame_tick is sampled at edge E0, new score/dots_left SHALL be visible after edge E23.
REQ-022 SHALL ignore frame_tick while busy: no queuing, no restart.
REQ-023 show changes during SCAN SHALL NOT affect the scan in progress; they are picked up by the next scan.
REQ-024 Bits in show that clear from 1 to 0 SHALL NOT decrement score or increment dots_left.
REQ-025 After level_clear, scans SHALL continue normally; score SHALL still saturate and dots_left SHALL remain 0.

Reset
REQ-026 Reset SHALL force, at the next edge, regardless of state (including mid-SCAN):
  - state=IDLE.
  - score=0.
  - dots_left=TOTAL_DOTS.
  - eat_pulse=0, level_clear=0, busy=0.
  - prev=0, snap=0, row counter=0, accumulator=0.
REQ-027 If Reset and frame_tick are both high at the same edge, Reset SHALL win and no scan SHALL start.

Verification
REQ-028 Reset, then show=0, frame_tick pulse -> busy high 23 cycles; score=0, dots_left=200, eat_pulse never high.
REQ-029 show bits 0, 15, 307 set (box bits also set), tick -> after E23: score=30, dots_left=197, eat_pulse high 1 cycle; repeat tick with same show -> score=30, no eat_pulse.
REQ-030 Set 200 non-box bits across successive ticks -> dots_left reaches 0, level_clear=1; further ticks -> level_clear stays 1, dots_left stays 0.
REQ-031 frame_tick pulsed at cycles 5 and 10 after a first tick; bit 20 changed mid-SCAN -> only one scan occurs; bit 20 counted on the next scan.
REQ-032 Reset asserted at SCAN row 10 -> next cycle busy=0, score=0, dots_left=200; a later tick with the same show counts all set bits as new.
REQ-033 Preload score near saturation via repeated full-row eats with DOT_POINTS=4096 -> score clamps at 65535, no wrap.
